// File: rtl/load_store_unit.sv
// Load/store unit between the core memory stage and a word-wide ram.
// Turns RV32I byte/half/word accesses into single-word ram accesses, does
// read-modify-write for SB/SH and sign/zero-extends sub-word loads.
// Optional feature macro: LSU_MISALIGN_TRAP_EN (defined: misaligned accesses
// return an error; undefined: offending low address bits are forced to zero).
module load_store_unit #(
    parameter int unsigned ADDR_W = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic [ADDR_W-1:0] address,
    output logic [31:0]       data_in,
    output logic              store,
    output logic              load,
    input  logic [31:0]       data_out
);

    typedef enum logic [2:0] {StIdle, StRd, StRdw, StWr, StResp} state_e;

    state_e            state_q, state_d;
    logic              we_q;
    logic [2:0]        funct3_q;
    logic [ADDR_W+1:0] addr_q;
    logic [15:0]       wdata_q;
    logic [31:0]       word_q;
    logic [31:0]       rdata_q;
    logic              err_q;

    logic              accept;
    logic              is_half;
    logic              is_word;
    logic              reserved;
    logic              misalign;
    logic              req_err;
    logic [ADDR_W+1:0] acc_addr;
    logic [1:0]        lane;
    logic [7:0]        rd_byte;
    logic [15:0]       rd_half;
    logic [31:0]       load_res;
    logic [31:0]       merged;
    logic              unused_addr;

    // Bits above the ram range only alias, they are never decoded.
    assign unused_addr = ^req_addr[31:ADDR_W+2];

    // Request decode: width class, reserved encodings, alignment.
    always_comb begin
        accept   = req_valid && (state_q == StIdle);
        is_half  = (req_funct3[1:0] == 2'b01);
        is_word  = (req_funct3[1:0] == 2'b10);
        reserved = (req_funct3 == 3'b011) || (req_funct3 == 3'b110) ||
                   (req_funct3 == 3'b111);
        misalign = (is_half && req_addr[0]) || (is_word && (req_addr[1:0] != 2'b00));
        acc_addr = req_addr[ADDR_W+1:0];
`ifdef LSU_MISALIGN_TRAP_EN
        req_err  = reserved || misalign;
`else
        req_err  = reserved;
        if (is_half) acc_addr[0] = 1'b0;
        if (is_word) acc_addr[1:0] = 2'b00;
`endif
    end

    // Lane extraction for loads and lane merge for sub-word stores.
    always_comb begin
        lane    = addr_q[1:0];
        rd_byte = data_out[{lane, 3'b000} +: 8];
        rd_half = addr_q[1] ? data_out[31:16] : data_out[15:0];
        case (funct3_q)
            3'b000:  load_res = {{24{rd_byte[7]}}, rd_byte};
            3'b001:  load_res = {{16{rd_half[15]}}, rd_half};
            3'b010:  load_res = data_out;
            3'b100:  load_res = {24'h0, rd_byte};
            3'b101:  load_res = {16'h0, rd_half};
            default: load_res = 32'h0;
        endcase
        merged = data_out;
        if (funct3_q[1:0] == 2'b00) begin
            merged[{lane, 3'b000} +: 8] = wdata_q[7:0];
        end else begin
            merged[{addr_q[1], 4'b0000} +: 16] = wdata_q;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (req_valid) begin
                    if (req_err) begin
                        state_d = StResp;
                    end else if (req_we && is_word) begin
                        state_d = StWr;
                    end else begin
                        state_d = StRd;
                    end
                end
            end
            StRd:    state_d = StRdw;
            StRdw:   state_d = we_q ? StWr : StResp;
            StWr:    state_d = StResp;
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Request capture and ram read-data handling.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q     <= 1'b0;
            funct3_q <= 3'b000;
            addr_q   <= '0;
            wdata_q  <= 16'h0;
            word_q   <= 32'h0;
            rdata_q  <= 32'h0;
            err_q    <= 1'b0;
        end else if (accept) begin
            we_q     <= req_we;
            funct3_q <= req_funct3;
            addr_q   <= acc_addr;
            wdata_q  <= req_wdata[15:0];
            word_q   <= req_wdata;
            rdata_q  <= 32'h0;
            err_q    <= req_err;
        end else if (state_q == StRdw) begin
            if (we_q) begin
                word_q <= merged;
            end else begin
                rdata_q <= load_res;
            end
        end
    end

    // Outputs decoded from state; response fields are zero outside RESP.
    always_comb begin
        req_ready  = (state_q == StIdle);
        load       = (state_q == StRd);
        store      = (state_q == StWr);
        resp_valid = (state_q == StResp);
        address    = addr_q[ADDR_W+1:2];
        data_in    = store ? word_q : 32'h0;
        resp_rdata = resp_valid ? rdata_q : 32'h0;
        resp_err   = resp_valid ? err_q : 1'b0;
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit with a behavioural word ram.
module tb_load_store_unit;

    localparam int unsigned ADDR_W = 12;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic              req_we = 1'b0;
    logic [2:0]        req_funct3 = 3'b000;
    logic [31:0]       req_addr = 32'h0;
    logic [31:0]       req_wdata = 32'h0;
    logic              resp_valid;
    logic [31:0]       resp_rdata;
    logic              resp_err;
    logic [ADDR_W-1:0] address;
    logic [31:0]       data_in;
    logic              store;
    logic              load;
    logic [31:0]       data_out = 32'h0;

    load_store_unit #(.ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .address    (address),
        .data_in    (data_in),
        .store      (store),
        .load       (load),
        .data_out   (data_out)
    );

    always #5 clk = ~clk;

    // Word ram: synchronous write, registered read.
    logic [31:0] mem [0:(1<<ADDR_W)-1];
    initial for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = 32'h0;
    always @(posedge clk) begin
        if (store) mem[address] <= data_in;
        if (load) data_out <= mem[address];
    end

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          ld_off;
        int          st_off;
        logic [31:0] addr;
        logic [31:0] din;
    } resp_t;

    resp_t sb[$];
    int    checks = 0;
    int    errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    function automatic resp_t ex(input logic [31:0] rd, input logic er, input int lat,
                                 input int lo, input int so, input logic [31:0] a,
                                 input logic [31:0] d);
        resp_t r;
        r.rdata = rd; r.err = er; r.lat = lat; r.ld_off = lo; r.st_off = so;
        r.addr = a; r.din = d;
        return r;
    endfunction

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input bit push, input resp_t r);
        bit ok = 0;
        if (push) sb.push_back(r);
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            ok = req_ready;
        end
        if (!ok) chk("req_ready_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    // Monitor: tracks strobes of the in-flight request, checks on resp_valid.
    int          cyc = 0;
    bit          active = 0;
    int          t0 = 0, ld_at = 0, st_at = 0, ld_n = 0, st_n = 0, off = 0;
    logic [31:0] s_addr = 0, s_din = 0;
    resp_t       e;
    always @(negedge clk) begin
        if (!rst_n) begin
            active = 0;
        end else begin
            if (load && store) chk("load_store_overlap", 32'd1, 32'd0);
            if (!active && (load || store)) chk("stray_strobe", {30'h0, load, store}, 32'd0);
            if (active) begin
                off = cyc - t0;
                if (load) begin ld_n++; ld_at = off; s_addr = 32'(address); end
                if (store) begin st_n++; st_at = off; s_addr = 32'(address); s_din = data_in; end
                if (resp_valid) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_resp", 32'd1, 32'd0);
                    end else begin
                        e = sb.pop_front();
                        chk("resp_latency", off, e.lat);
                        chk("resp_rdata", resp_rdata, e.rdata);
                        chk("resp_err", {31'h0, resp_err}, {31'h0, e.err});
                        chk("load_cycle", ld_at, e.ld_off);
                        chk("store_cycle", st_at, e.st_off);
                        chk("strobe_count", ld_n + st_n,
                            32'((e.ld_off != 0 ? 1 : 0) + (e.st_off != 0 ? 1 : 0)));
                        if (ld_n + st_n > 0) chk("ram_address", s_addr, e.addr);
                        if (e.st_off != 0) chk("ram_data_in", s_din, e.din);
                    end
                    active = 0;
                end
            end
            if (req_valid && req_ready) begin
                active = 1; t0 = cyc; ld_at = 0; st_at = 0; ld_n = 0; st_n = 0;
            end
        end
        cyc++;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values.
        #3;
        chk("rst_req_ready", {31'h0, req_ready}, 32'd1);
        chk("rst_resp_valid", {31'h0, resp_valid}, 32'd0);
        chk("rst_strobes", {30'h0, load, store}, 32'd0);
        chk("rst_address", 32'(address), 32'd0);
        chk("rst_data_in", data_in, 32'd0);
        chk("rst_resp", {resp_rdata[30:0], resp_err}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // 1: SW then LW
        issue(1, 3'b010, 32'h1EC, 32'h1234_CDEF, 1, ex(0, 0, 2, 0, 1, 123, 32'h1234_CDEF));
        issue(0, 3'b010, 32'h1EC, 0, 1, ex(32'h1234_CDEF, 0, 3, 1, 0, 123, 0));
        // 2: SB read-modify-write
        issue(1, 3'b000, 32'h1ED, 32'h0000_00AA, 1, ex(0, 0, 4, 1, 3, 123, 32'h1234_AAEF));
        issue(0, 3'b010, 32'h1EC, 0, 1, ex(32'h1234_AAEF, 0, 3, 1, 0, 123, 0));
        // 3: sub-word loads
        issue(0, 3'b000, 32'h1ED, 0, 1, ex(32'hFFFF_FFAA, 0, 3, 1, 0, 123, 0));
        issue(0, 3'b100, 32'h1ED, 0, 1, ex(32'h0000_00AA, 0, 3, 1, 0, 123, 0));
        issue(0, 3'b001, 32'h1EE, 0, 1, ex(32'h0000_1234, 0, 3, 1, 0, 123, 0));
        issue(0, 3'b101, 32'h1EC, 0, 1, ex(32'h0000_AAEF, 0, 3, 1, 0, 123, 0));
        issue(0, 3'b000, 32'h1EC, 0, 1, ex(32'hFFFF_FFEF, 0, 3, 1, 0, 123, 0));
        // 4: misaligned LW / LH
`ifdef LSU_MISALIGN_TRAP_EN
        issue(0, 3'b010, 32'h1ED, 0, 1, ex(0, 1, 1, 0, 0, 0, 0));
        issue(0, 3'b001, 32'h1ED, 0, 1, ex(0, 1, 1, 0, 0, 0, 0));
`else
        issue(0, 3'b010, 32'h1ED, 0, 1, ex(32'h1234_AAEF, 0, 3, 1, 0, 123, 0));
        issue(0, 3'b001, 32'h1ED, 0, 1, ex(32'hFFFF_AAEF, 0, 3, 1, 0, 123, 0));
`endif
        // SH upper lane, then loads of it
        issue(1, 3'b001, 32'h1EE, 32'h0000_8001, 1, ex(0, 0, 4, 1, 3, 123, 32'h8001_AAEF));
        issue(0, 3'b001, 32'h1EE, 0, 1, ex(32'hFFFF_8001, 0, 3, 1, 0, 123, 0));
        issue(0, 3'b100, 32'h1EF, 0, 1, ex(32'h0000_0080, 0, 3, 1, 0, 123, 0));
        issue(0, 3'b000, 32'h1EF, 0, 1, ex(32'hFFFF_FF80, 0, 3, 1, 0, 123, 0));
        // 5: top-of-range word and aliasing to word 0
        issue(1, 3'b010, 32'h0, 32'hA5A5_0001, 1, ex(0, 0, 2, 0, 1, 0, 32'hA5A5_0001));
        issue(1, 3'b010, 32'h3FFC, 32'hFFFF_FFFF, 1, ex(0, 0, 2, 0, 1, 32'hFFF, 32'hFFFF_FFFF));
        issue(0, 3'b010, 32'h4000, 0, 1, ex(32'hA5A5_0001, 0, 3, 1, 0, 0, 0));
        issue(0, 3'b010, 32'h3FFC, 0, 1, ex(32'hFFFF_FFFF, 0, 3, 1, 0, 32'hFFF, 0));
        // 6: reset in RD of an SH
        repeat (6) @(posedge clk);
        #1;
        issue(1, 3'b001, 32'h1EC, 32'h0000_5555, 0, ex(0, 0, 0, 0, 0, 0, 0));
        chk("sh_in_rd_load", {31'h0, load}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("async_rst_strobes", {30'h0, load, store}, 32'd0);
        chk("async_rst_ready", {31'h0, req_ready}, 32'd1);
        chk("async_rst_resp", {31'h0, resp_valid}, 32'd0);
        chk("async_rst_data_in", data_in, 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_ready", {31'h0, req_ready}, 32'd1);
        issue(0, 3'b010, 32'h1EC, 0, 1, ex(32'h8001_AAEF, 0, 3, 1, 0, 123, 0));
        // reserved funct3
        issue(0, 3'b011, 32'h10, 0, 1, ex(0, 1, 1, 0, 0, 0, 0));
        issue(1, 3'b110, 32'h1EC, 32'hDEAD_BEEF, 1, ex(0, 1, 1, 0, 0, 0, 0));
        issue(0, 3'b111, 32'h1EC, 0, 1, ex(0, 1, 1, 0, 0, 0, 0));
        issue(0, 3'b010, 32'h1EC, 0, 1, ex(32'h8001_AAEF, 0, 3, 1, 0, 123, 0));

        for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge clk);
        repeat (2) @(negedge clk);
        chk("responses_outstanding", sb.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
